// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    // Debounce FSM states.
    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        PRESSED,
        RELEASE
    } kp_state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Column-slot divider: emits a one-cycle tick on the last cycle of every
// SCAN_DIV-cycle slot.
module scan_tick_gen #(
    parameter int SCAN_DIV = 1000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running slot counter, wraps after SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one-cold column strobes, synchronizes the
// row lines, folds four column slots into one scan result and debounces
// presses and releases over DEB_SCANS consecutive identical scans.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int DEB_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_ROWS-1:0] row,
    output logic [NUM_COLS-1:0] col,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int CW = $clog2(DEB_SCANS + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_SCANS - 1);

    logic                tick;
    logic [1:0]          idx;
    logic [1:0]          idx_nxt;
    logic [NUM_ROWS-1:0] row_s1;
    logic [NUM_ROWS-1:0] row_s2;

    // Scan accumulation across the slots of the current scan
    logic [1:0]          acc_cnt;
    logic [CODE_W-1:0]   acc_code;
    logic [2:0]          slot_n;
    logic [1:0]          slot_row;
    logic [1:0]          prev_n;
    logic [CODE_W-1:0]   prev_code;
    logic [2:0]          sum_n;
    logic [1:0]          scan_n;
    logic [CODE_W-1:0]   scan_code;
    logic                scan_done;

    // Debounce FSM
    kp_state_t           state, state_d;
    logic [CODE_W-1:0]   cand, cand_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic [CODE_W-1:0]   code_d;
    logic                valid_d;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign idx_nxt   = idx + 2'd1;
    assign scan_done = tick && (idx == 2'd3);

    // Column index and registered one-cold strobe advance together on each tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd0;
            col <= 4'b1110;
        end else if (tick) begin
            idx <= idx_nxt;
            col <= ~(4'b0001 << idx_nxt);
        end
    end

    // Two-flop synchronizer for the asynchronous row lines (idle-high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_s1 <= '1;
            row_s2 <= '1;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
        end
    end

    // Fold the current slot into the running scan result; slot 0 starts fresh.
    always_comb begin
        slot_n   = 3'd0;
        slot_row = 2'd0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_s2[r])
                slot_n = slot_n + 3'd1;
        end
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (!row_s2[r])
                slot_row = 2'(r);
        end
        prev_n    = (idx == 2'd0) ? 2'd0 : acc_cnt;
        prev_code = (idx == 2'd0) ? '0 : acc_code;
        sum_n     = {1'b0, prev_n} + slot_n;
        scan_n    = (sum_n >= 3'd2) ? 2'd2 : sum_n[1:0];
        scan_code = ((prev_n == 2'd0) && (slot_n != 3'd0)) ? {idx, slot_row} : prev_code;
    end

    // Keep the partial scan result, sampled on the last cycle of each slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= 2'd0;
            acc_code <= '0;
        end else if (tick) begin
            acc_cnt  <= scan_n;
            acc_code <= scan_code;
        end
    end

    // Debounce state register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            state     <= state_d;
            cand      <= cand_d;
            cnt       <= cnt_d;
            key_code  <= code_d;
            key_valid <= valid_d;
        end
    end

    // Next-state logic, evaluated once per completed scan.
    always_comb begin
        state_d = state;
        cand_d  = cand;
        cnt_d   = cnt;
        code_d  = key_code;
        valid_d = 1'b0;
        if (scan_done) begin
            unique case (state)
                IDLE: begin
                    if (scan_n == 2'd1) begin
                        if (DEB_SCANS == 1) begin
                            state_d = PRESSED;
                            code_d  = scan_code;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = CONFIRM;
                            cand_d  = scan_code;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                CONFIRM: begin
                    if ((scan_n == 2'd1) && (scan_code == cand)) begin
                        if (cnt == DEB_LAST) begin
                            state_d = PRESSED;
                            code_d  = cand;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + CW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (scan_n == 2'd0) begin
                        if (DEB_SCANS == 1) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                RELEASE: begin
                    if (scan_n == 2'd0) begin
                        if (cnt == DEB_LAST) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + CW'(1);
                        end
                    end else begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign key_held = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized bench for keypad_scanner with a scan-level reference model.
module tb_keypad_scanner;

    localparam int DIV  = 4;
    localparam int DEB  = 3;
    localparam int SCAN = 4 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keys;   // bit c*4+r set = key at column c, row r closed

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: run lengths of matching scans and release scans.
    int         m_run;
    int         m_rel;
    int         m_cand;
    bit         m_locked;
    bit         m_pulse;
    logic [3:0] m_code;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV  (DIV),
        .DEB_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad matrix: a closed key pulls its row low only while its column is driven.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (!col[c] && keys[c*4 + r])
                    row[r] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run    = 0;
        m_rel    = 0;
        m_cand   = -1;
        m_locked = 0;
        m_pulse  = 0;
        m_code   = 4'd0;
    endtask

    // One completed scan with the current key set.
    task automatic model_scan();
        int n;
        int first;
        n     = $countones(keys);
        first = -1;
        for (int i = 15; i >= 0; i--)
            if (keys[i]) first = i;
        m_pulse = 0;
        if (!m_locked) begin
            if (n == 1 && (m_run == 0 || first == m_cand)) begin
                if (m_run == 0) m_cand = first;
                m_run++;
                if (m_run == DEB) begin
                    m_locked = 1;
                    m_pulse  = 1;
                    m_code   = 4'(m_cand);
                    m_run    = 0;
                    m_rel    = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 0) m_rel++;
            else        m_rel = 0;
            if (m_rel == DEB) begin
                m_locked = 0;
                m_rel    = 0;
            end
        end
    endtask

    // Step ncyc clocks from the start of a scan, checking every cycle.
    task automatic run_scan(input int ncyc);
        logic [3:0] exp_col;
        logic [3:0] one;
        for (int k = 1; k <= ncyc; k++) begin
            @(posedge clk);
            #1;
            if (k == SCAN) model_scan();
            one     = 4'b0001;
            exp_col = ~(one << ((k / DIV) % 4));
            check("col", 32'(col), 32'(exp_col));
            check("key_valid", 32'(key_valid), (k == SCAN) ? 32'(m_pulse) : 32'd0);
            check("key_held", 32'(key_held), 32'(m_locked));
            check("key_code", 32'(key_code), 32'(m_code));
        end
    endtask

    task automatic run_scans(input int n);
        for (int s = 0; s < n; s++) run_scan(SCAN);
    endtask

    // Async assert, check reset values at once, release just after a falling edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check("rst_col", 32'(col), 32'hE);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_code", 32'(key_code), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int len;
        int pick;
        keys = 16'h0;
        model_reset();
        #2;
        apply_reset();

        // Bouncy press on col0/row0: never accepted, code stays 0
        for (int i = 0; i < 4; i++) begin
            keys = 16'h0001; run_scans(1);
            keys = 16'h0000; run_scans(1);
        end

        // Steady col2/row1 from a fresh reset: single pulse with code 9
        keys = 16'h0;
        @(negedge clk);
        keys = 16'h0200;
        apply_reset();
        run_scans(5);
        keys = 16'h0; run_scans(4);

        // Two keys together: rejected while columns keep cycling
        keys = (16'h1 << 7) | (16'h1 << 12);
        run_scans(5);
        keys = 16'h0; run_scans(2);

        // Long hold of col3/row3, release, then col0/row2
        keys = 16'h8000; run_scans(20);
        keys = 16'h0;    run_scans(4);
        keys = 16'h0004; run_scans(5);
        // Second key pressed while first still held is ignored
        keys = 16'h0024; run_scans(3);
        keys = 16'h0;    run_scans(4);

        // Reset during confirmation: no stale candidate afterwards
        keys = 16'h0020;
        run_scans(2);
        run_scan(5);
        #2;
        apply_reset();
        run_scans(5);
        keys = 16'h0; run_scans(4);

        // Random key sequences
        for (int b = 0; b < 60; b++) begin
            pick = $urandom_range(0, 9);
            len  = $urandom_range(1, 6);
            if (pick < 3)
                keys = 16'h0;
            else if (pick < 8)
                keys = 16'h1 << $urandom_range(0, 15);
            else
                keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
            run_scans(len);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
